// File: rtl/sw_input_port.sv
// Push-button input port: synchronises and debounces a button, captures the switch
// bank on each clean press and holds it for the CPU until the read is acknowledged.
module sw_input_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button_in,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              in_ack,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              overrun_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic              r_btn_s1;
  logic              r_btn_s2;
  logic [DATA_W-1:0] r_sw_s1;
  logic [DATA_W-1:0] r_sw_s2;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_deb;
  logic              r_deb_d;
  state_t            r_state;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_ovr;
  logic              w_press;

  // Two-flop synchronisers for the button and every switch bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= button_in;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounced level flips on the edge where the mismatch run reaches DEBOUNCE_CYCLES
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      if (r_btn_s2 != r_deb) begin
        if (r_cnt == CNT_LAST) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d;

  // Handshake FSM; RELEASE keeps a still-held button from re-capturing after an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_data  <= r_sw_s2;
            r_ready <= 1'b1;
            r_state <= READY;
          end
        end
        READY: begin
          if (w_press) begin
            r_ovr <= 1'b1;
          end
          if (in_ack) begin
            r_ready <= 1'b0;
            r_state <= r_deb ? RELEASE : IDLE;
          end
        end
        RELEASE: begin
          if (!r_deb) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out   = r_ready;
  assign data_out    = r_data;
  assign overrun_out = r_ovr;

endmodule
